// File: rtl/prio_arb_pkg.sv
// Shared constants for the prio_arb_reg arbiter: arbitration modes and stall counter width.
package prio_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int STALL_CW  = 16;

endpackage

// File: rtl/prio_arb_pick.sv
// Combinational find-first-set over req, starting at index start and wrapping N-1 -> 0.
// Zero latency; no backpressure (pure function of its inputs).
module prio_arb_pick
    import prio_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] idx,
    output logic          found
);

    int            j;
    logic [CW-1:0] jj;

    // start is always < N, so a single subtraction folds the wrap without a modulo
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = CW'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/prio_arb_reg.sv
// N-channel valid/ready arbiter (fixed or round-robin) into one output register; 1-cycle latency.
// Backpressure: a stalled output drops every req_rdy; optional stall_cnt via PRIO_ARB_REG_STALL_CNT_EN.
module prio_arb_reg
    import prio_arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int RR  = ARB_FIXED,
    parameter int CW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req_vld,
    input  logic [NCH*DW-1:0] req_data,
    output logic [NCH-1:0]    req_rdy,
    output logic              out_vld,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ch,
    input  logic              out_rdy,
    output logic              busy
`ifdef PRIO_ARB_REG_STALL_CNT_EN
    ,
    output logic [STALL_CW-1:0] stall_cnt
`endif
);

    logic           load;
    logic           grant;
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  start;
    logic [NCH-1:0] pick_gnt;
    logic [CW-1:0]  pick_idx;
    logic           pick_found;

    assign start = (RR == ARB_RR) ? ptr : '0;

    prio_arb_pick #(
        .N  (NCH),
        .CW (CW)
    ) u_pick (
        .req   (req_vld),
        .start (start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Register may take a new word when empty or when its current word leaves this edge
    assign load    = ~out_vld | out_rdy;
    assign grant   = pick_found & load;
    assign req_rdy = grant ? pick_gnt : '0;
    assign busy    = out_vld & ~out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
        end else if (grant) begin
            out_vld  <= 1'b1;
            out_data <= req_data[pick_idx*DW +: DW];
            out_ch   <= pick_idx;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

    // Explicit wrap: NCH need not be a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant && (RR == ARB_RR)) begin
            ptr <= (pick_idx == CW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

`ifdef PRIO_ARB_REG_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_vld && out_rdy) begin
            stall_cnt <= '0;
        end else if (busy && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_prio_arb_reg.sv
// Three arbiter instances (fixed/4ch, RR/4ch, RR/3ch) on shared stimulus, checked against a queue-free behavioural model.
module tb_prio_arb_reg;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [31:0] req_data;
    logic        out_rdy;

    logic [3:0]  f_req_rdy, r_req_rdy;
    logic [2:0]  t_req_rdy;
    logic        f_out_vld, r_out_vld, t_out_vld;
    logic [7:0]  f_out_data, r_out_data, t_out_data;
    logic [1:0]  f_out_ch, r_out_ch, t_out_ch;
    logic        f_busy, r_busy, t_busy;
    logic [15:0] f_stall, r_stall, t_stall;

    prio_arb_reg #(.NCH(4), .DW(8), .RR(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
        .req_rdy(f_req_rdy), .out_vld(f_out_vld), .out_data(f_out_data),
        .out_ch(f_out_ch), .out_rdy(out_rdy), .busy(f_busy)
`ifdef PRIO_ARB_REG_STALL_CNT_EN
        , .stall_cnt(f_stall)
`endif
    );

    prio_arb_reg #(.NCH(4), .DW(8), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
        .req_rdy(r_req_rdy), .out_vld(r_out_vld), .out_data(r_out_data),
        .out_ch(r_out_ch), .out_rdy(out_rdy), .busy(r_busy)
`ifdef PRIO_ARB_REG_STALL_CNT_EN
        , .stall_cnt(r_stall)
`endif
    );

    prio_arb_reg #(.NCH(3), .DW(8), .RR(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld[2:0]), .req_data(req_data[23:0]),
        .req_rdy(t_req_rdy), .out_vld(t_out_vld), .out_data(t_out_data),
        .out_ch(t_out_ch), .out_rdy(out_rdy), .busy(t_busy)
`ifdef PRIO_ARB_REG_STALL_CNT_EN
        , .stall_cnt(t_stall)
`endif
    );

`ifndef PRIO_ARB_REG_STALL_CNT_EN
    assign f_stall = '0;
    assign r_stall = '0;
    assign t_stall = '0;
`endif

    logic [3:0]  a_rdy  [3];
    logic        a_vld  [3];
    logic [7:0]  a_data [3];
    logic [1:0]  a_ch   [3];
    logic        a_busy [3];
    logic [15:0] a_stall[3];

    assign a_rdy[0] = f_req_rdy;            assign a_rdy[1] = r_req_rdy;
    assign a_rdy[2] = {1'b0, t_req_rdy};
    assign a_vld[0] = f_out_vld;            assign a_vld[1] = r_out_vld;   assign a_vld[2] = t_out_vld;
    assign a_data[0] = f_out_data;          assign a_data[1] = r_out_data; assign a_data[2] = t_out_data;
    assign a_ch[0] = f_out_ch;              assign a_ch[1] = r_out_ch;     assign a_ch[2] = t_out_ch;
    assign a_busy[0] = f_busy;              assign a_busy[1] = r_busy;     assign a_busy[2] = t_busy;
    assign a_stall[0] = f_stall;            assign a_stall[1] = r_stall;   assign a_stall[2] = t_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, what the output register and RR pointer should hold
    int          nch [3] = '{4, 4, 3};
    int          rrm [3] = '{0, 1, 1};
    bit          m_vld  [3];
    logic [7:0]  m_data [3];
    int          m_ch   [3];
    int          m_ptr  [3];
    int          m_stall[3];
    int          checks;
    int          errors;

    function automatic int winner(int i);
        int s;
        s = (rrm[i] != 0) ? m_ptr[i] : 0;
        for (int k = 0; k < nch[i]; k++) begin
            int c;
            c = (s + k) % nch[i];
            if (req_vld[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int i);
        int w;
        w = winner(i);
        if ((!m_vld[i] || out_rdy) && w >= 0) return 4'(1 << w);
        return 4'b0000;
    endfunction

    function automatic bit exp_busy(int i);
        return m_vld[i] && !out_rdy;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_vld[i] = 1'b0; m_data[i] = 8'h00; m_ch[i] = 0; m_ptr[i] = 0; m_stall[i] = 0;
        end
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUTs
    task automatic tick();
        for (int i = 0; i < 3; i++) begin
            int w;
            bit hs;
            w  = winner(i);
            hs = m_vld[i] && out_rdy;
            if (hs) m_stall[i] = 0;
            else if (exp_busy(i) && m_stall[i] < 65535) m_stall[i] = m_stall[i] + 1;
            if ((!m_vld[i] || out_rdy) && w >= 0) begin
                m_vld[i]  = 1'b1;
                m_data[i] = req_data[w*8 +: 8];
                m_ch[i]   = w;
                if (rrm[i] != 0) m_ptr[i] = (w + 1) % nch[i];
            end else if (hs) begin
                m_vld[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_vld = '0;
        out_rdy = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '0; req_data = '0; out_rdy = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_vld[i] !== 1'b0 || a_data[i] !== 8'h00 || a_ch[i] !== 2'd0 || a_rdy[i] !== 4'b0000) begin
                errors++;
                $display("FAIL reset inst%0d: vld=%b data=%h ch=%0d rdy=%b, want all zero",
                         i, a_vld[i], a_data[i], a_ch[i], a_rdy[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        out_rdy = 1'b1; req_data = 32'h0022_1100; req_vld = 4'b0110;
        #1;
        checks++;
        if (a_rdy[0] !== 4'b0010) begin
            errors++; $display("FAIL fixed_rdy0: got %b want 0010", a_rdy[0]);
        end
        tick();
        checks++;
        if (a_vld[0] !== 1'b1 || a_data[0] !== 8'h11 || a_ch[0] !== 2'd1) begin
            errors++; $display("FAIL fixed_out0: vld=%b data=%h ch=%0d want 1/11/1", a_vld[0], a_data[0], a_ch[0]);
        end
        req_vld = 4'b0100;
        #1;
        checks++;
        if (a_rdy[0] !== 4'b0100) begin
            errors++; $display("FAIL fixed_rdy1: got %b want 0100", a_rdy[0]);
        end
        tick();
        checks++;
        if (a_vld[0] !== 1'b1 || a_data[0] !== 8'h22 || a_ch[0] !== 2'd2) begin
            errors++; $display("FAIL fixed_out1: vld=%b data=%h ch=%0d want 1/22/2", a_vld[0], a_data[0], a_ch[0]);
        end
    endtask

    task automatic test_rr_sequence();
        int seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_vld = 4'hF; out_rdy = 1'b1; req_data = $urandom;
        for (int s = 0; s < 5; s++) begin
            tick();
            checks++;
            if (a_vld[1] !== 1'b1 || int'(a_ch[1]) != seq[s] || a_data[1] !== m_data[1]) begin
                errors++;
                $display("FAIL rr_seq step%0d: vld=%b ch=%0d data=%h want 1/%0d/%h",
                         s, a_vld[1], a_ch[1], a_data[1], seq[s], m_data[1]);
            end
            checks++;
            if (int'(a_ch[2]) != m_ch[2]) begin
                errors++; $display("FAIL rr3_seq step%0d: ch=%0d want %0d", s, a_ch[2], m_ch[2]);
            end
        end
    endtask

    task automatic test_rr3_wrap();
        do_reset();
        req_vld = 4'b0100; out_rdy = 1'b1; req_data = 32'h00CC_BBAA;
        tick();
        checks++;
        if (a_vld[2] !== 1'b1 || a_ch[2] !== 2'd2 || a_data[2] !== 8'hCC) begin
            errors++; $display("FAIL rr3_first: vld=%b ch=%0d data=%h want 1/2/cc", a_vld[2], a_ch[2], a_data[2]);
        end
        req_vld = 4'b0101;
        #1;
        checks++;
        if (a_rdy[2] !== 4'b0001) begin
            errors++; $display("FAIL rr3_wrap_rdy: got %b want 0001", a_rdy[2]);
        end
        tick();
        checks++;
        if (a_ch[2] !== 2'd0 || a_data[2] !== 8'hAA) begin
            errors++; $display("FAIL rr3_wrap: ch=%0d data=%h want 0/aa", a_ch[2], a_data[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        out_rdy = 1'b1; req_vld = 4'b0001; req_data = $urandom;
        tick();
        held = m_data[0];
        out_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a_rdy[i] !== 4'b0000 || a_busy[i] !== 1'b1) begin
                    errors++; $display("FAIL stall_ctl inst%0d cyc%0d: rdy=%b busy=%b want 0000/1", i, s, a_rdy[i], a_busy[i]);
                end
            end
            tick();
            checks++;
            if (a_data[0] !== held || a_vld[0] !== 1'b1) begin
                errors++; $display("FAIL stall_hold cyc%0d: data=%h vld=%b want %h/1", s, a_data[0], a_vld[0], held);
            end
        end
`ifdef PRIO_ARB_REG_STALL_CNT_EN
        checks++;
        if (a_stall[0] !== 16'd5) begin
            errors++; $display("FAIL stall_cnt5: got %0d want 5", a_stall[0]);
        end
`endif
        out_rdy = 1'b1;
        tick();
`ifdef PRIO_ARB_REG_STALL_CNT_EN
        checks++;
        if (a_stall[0] !== 16'd0) begin
            errors++; $display("FAIL stall_cnt_clr: got %0d want 0", a_stall[0]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        req_vld = 4'b1000; out_rdy = 1'b1; req_data = 32'h5A00_0000;
        #1;
        checks++;
        if (a_vld[0] !== 1'b1 || a_rdy[0] !== 4'b1000) begin
            errors++; $display("FAIL b2b_pre: vld=%b rdy=%b want 1/1000", a_vld[0], a_rdy[0]);
        end
        tick();
        checks++;
        if (a_vld[0] !== 1'b1 || a_ch[0] !== 2'd3 || a_vld[1] !== 1'b1 || a_ch[1] !== 2'd3 || a_data[0] !== 8'h5A) begin
            errors++;
            $display("FAIL b2b: f vld=%b ch=%0d data=%h r vld=%b ch=%0d want 1/3/5a 1/3",
                     a_vld[0], a_ch[0], a_data[0], a_vld[1], a_ch[1]);
        end
        checks++;
        if (a_vld[2] !== 1'b0) begin
            errors++; $display("FAIL b2b_drain3: vld=%b want 0", a_vld[2]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_vld  = 4'($urandom);
            req_data = $urandom;
            out_rdy  = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a_rdy[i] !== exp_rdy(i) || a_busy[i] !== exp_busy(i)) begin
                    errors++;
                    $display("FAIL rand_ctl inst%0d cyc%0d: rdy=%b busy=%b want %b/%b",
                             i, c, a_rdy[i], a_busy[i], exp_rdy(i), exp_busy(i));
                end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a_vld[i] !== m_vld[i] || a_data[i] !== m_data[i] || int'(a_ch[i]) != m_ch[i]) begin
                    errors++;
                    $display("FAIL rand_out inst%0d cyc%0d: vld=%b data=%h ch=%0d want %b/%h/%0d",
                             i, c, a_vld[i], a_data[i], a_ch[i], m_vld[i], m_data[i], m_ch[i]);
                end
`ifdef PRIO_ARB_REG_STALL_CNT_EN
                checks++;
                if (int'(a_stall[i]) != m_stall[i]) begin
                    errors++; $display("FAIL rand_stall inst%0d cyc%0d: got %0d want %0d", i, c, a_stall[i], m_stall[i]);
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid();
        req_vld = 4'hF; out_rdy = 1'b1; req_data = $urandom;
        tick();
        out_rdy = 1'b0;
        tick();
        #2;
        rst_n = 1'b0; req_vld = '0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_vld[i] !== 1'b0 || a_data[i] !== 8'h00 || a_ch[i] !== 2'd0 || a_stall[i] !== 16'd0) begin
                errors++;
                $display("FAIL mid_reset inst%0d: vld=%b data=%h ch=%0d stall=%0d want all zero",
                         i, a_vld[i], a_data[i], a_ch[i], a_stall[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; req_vld = 4'hF; out_rdy = 1'b1;
        #1;
        checks++;
        if (a_rdy[1] !== 4'b0001) begin
            errors++; $display("FAIL mid_reset_rr_rdy: got %b want 0001", a_rdy[1]);
        end
        tick();
        checks++;
        if (a_vld[1] !== 1'b1 || a_ch[1] !== 2'd0) begin
            errors++; $display("FAIL mid_reset_rr: vld=%b ch=%0d want 1/0", a_vld[1], a_ch[1]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_rr3_wrap();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
